bp_sigmoid_gate: RTL

BP_SIGMOID_GATE -- requirements
Module: bp_sigmoid_gate

---
 rtl/bp_sigmoid_gate_if.sv | 37 +++
 rtl/bp_sigmoid_gate.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bp_sigmoid_gate_if.sv
// Port bundle for bp_sigmoid_gate: start/operands, RAM read port,
// and the delta/gradient result stream.
interface bp_sigmoid_gate_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 2
);
  logic             i_start;
  logic [WIDTH-1:0] i_act;
  logic [WIDTH-1:0] i_err;
  logic [WIDTH-1:0] i_data;
  logic             o_rd_en;
  logic             o_rd_sel;
  logic [AW-1:0]    o_rd_addr;
  logic [WIDTH-1:0] o_delta;
  logic [WIDTH-1:0] o_grad;
  logic             o_grad_valid;
  logic             o_grad_sel;
  logic [AW-1:0]    o_grad_idx;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_act, i_err, i_data,
    input  o_rd_en, o_rd_sel, o_rd_addr,
    input  o_delta, o_grad, o_grad_valid,
    input  o_grad_sel, o_grad_idx,
    input  o_busy, o_done
  );

  modport slave (
    input  i_start, i_act, i_err, i_data,
    output o_rd_en, o_rd_sel, o_rd_addr,
    output o_delta, o_grad, o_grad_valid,
    output o_grad_sel, o_grad_idx,
    output o_busy, o_done
  );
endinterface

// File: rtl/bp_sigmoid_gate.sv
// Sigmoid-gate backprop: delta = o*(1-o)*err, then streams
// delta*x and delta*h_prev gradients from an external sync RAM.
module bp_sigmoid_gate #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int NUM_X = 4,
  parameter int NUM_H = 4
) (
  input  logic clk,
  input  logic rst,
  bp_sigmoid_gate_if.slave bus
);
  localparam int MAXN = (NUM_X > NUM_H) ? NUM_X : NUM_H;
  localparam int AW   = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam logic [AW-1:0] X_LAST = AW'(NUM_X - 1);
  localparam logic [AW-1:0] H_LAST = AW'(NUM_H - 1);
  localparam logic [AW-1:0] DR_LAST = AW'(1);
  localparam logic signed [WIDTH:0] ONE =
    {{WIDTH{1'b0}}, 1'b1} << FRAC;

  typedef enum logic [2:0] {
    IDLE, D1, D2, GX, GH, DRAIN, DONE
  } state_t;

  state_t state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  logic signed [WIDTH-1:0] act_q, err_q;
  logic signed [WIDTH-1:0] d1_q, delta_q, grad_q;
  logic signed [WIDTH:0]   one_m_act;
  logic                    p_v, p_sel, gv_q, gsel_q;
  logic [AW-1:0]           p_idx, gidx_q;
  logic                    rd_en;

  function automatic logic signed [WIDTH:0] sext(
    input logic [WIDTH-1:0] v
  );
    return {v[WIDTH-1], v};
  endfunction

  // Q-format multiply: full product, arithmetic shift, clamp.
  function automatic logic signed [WIDTH-1:0] fmul(
    input logic signed [WIDTH:0] a,
    input logic signed [WIDTH:0] b
  );
    logic signed [2*WIDTH+1:0] p;
    logic signed [2*WIDTH+1:0] s;
    p = $signed({{(WIDTH+1){a[WIDTH]}}, a}) *
        $signed({{(WIDTH+1){b[WIDTH]}}, b});
    s = p >>> FRAC;
    if ((&s[2*WIDTH+1:WIDTH-1]) | ~(|s[2*WIDTH+1:WIDTH-1]))
      return s[WIDTH-1:0];
    else if (s[2*WIDTH+1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE:  if (bus.i_start) state_nxt = D1;
      D1:    state_nxt = D2;
      D2: begin
        state_nxt = GX;
        cnt_nxt   = '0;
      end
      GX: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == X_LAST) begin
          state_nxt = GH;
          cnt_nxt   = '0;
        end
      end
      GH: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == H_LAST) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == DR_LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign rd_en     = (state == GX) || (state == GH);
  assign one_m_act = ONE - sext(act_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q   <= '0;
      err_q   <= '0;
      d1_q    <= '0;
      delta_q <= '0;
      grad_q  <= '0;
      p_v     <= 1'b0;
      p_sel   <= 1'b0;
      p_idx   <= '0;
      gv_q    <= 1'b0;
      gsel_q  <= 1'b0;
      gidx_q  <= '0;
    end else begin
      if (state == IDLE && bus.i_start) begin
        act_q <= bus.i_act;
        err_q <= bus.i_err;
      end
      if (state == D1)
        d1_q <= fmul(sext(act_q), one_m_act);
      if (state == D2)
        delta_q <= fmul(sext(d1_q), sext(err_q));
      // stage 1 tracks the RAM latency, stage 2 multiplies
      p_v   <= rd_en;
      p_sel <= (state == GH);
      p_idx <= rd_en ? cnt : '0;
      gv_q  <= p_v;
      if (p_v) begin
        grad_q <= fmul(sext(delta_q), sext(bus.i_data));
        gsel_q <= p_sel;
        gidx_q <= p_idx;
      end
    end
  end

  assign bus.o_rd_en      = rd_en;
  assign bus.o_rd_sel     = (state == GH);
  assign bus.o_rd_addr    = rd_en ? cnt : '0;
  assign bus.o_delta      = delta_q;
  assign bus.o_grad       = grad_q;
  assign bus.o_grad_valid = gv_q;
  assign bus.o_grad_sel   = gsel_q;
  assign bus.o_grad_idx   = gidx_q;
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_done       = (state == DONE);
endmodule
